// File: rtl/ram_responder_pkg.sv
// Shared constants, request payload and address-decode helper for ram_responder.
package ram_responder_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CADDR_W  = 32;
  localparam int unsigned IO_DEC_W = 18;

  localparam logic [IO_DEC_W-1:0] IO_BASE = 18'h30000;
  localparam logic [IO_DEC_W-1:0] IO_HALT = 18'h30004;

  localparam logic READ_SIT  = 1'b1;
  localparam logic WRITE_SIT = 1'b0;

  typedef struct packed {
    logic               rw;
    logic [CADDR_W-1:0] addr;
    logic [BYTE_W-1:0]  data;
  } ctrl_req_t;

  // Bits [17:16] == 2'b11 select the I/O window; higher bits are don't-care.
  function automatic logic is_io(input logic [CADDR_W-1:0] a);
    return a[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/ram_responder_io_fifo.sv
// io_fifo: byte FIFO with power-of-two depth; push onto a full FIFO succeeds
// only when a pop happens on the same edge.
module io_fifo
  import ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       push_data,
  input  logic                    pop,
  output logic [BYTE_W-1:0]       head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Storage is never reset, so the head is masked while empty.
  assign head    = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_responder.sv
// ram_responder: byte RAM with latency-1 reads; with RAM_RESPONDER_IO_EN defined
// a TX/RX FIFO pair and halt register occupy the 0x30000 I/O window.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               read_write_flag_from_controller,
  input  logic [CADDR_W-1:0] address_from_controller,
  input  logic [BYTE_W-1:0]  data_from_controller,
  output logic [BYTE_W-1:0]  data_to_controller,
  output logic               io_buffer_full_out,
  output logic [BYTE_W-1:0]  tx_data_out,
  output logic               tx_valid_out,
  input  logic               tx_ready_in,
  input  logic [BYTE_W-1:0]  rx_data_in,
  input  logic               rx_valid_in,
  output logic               rx_full_out,
  output logic               sim_end_out,
  output logic               overflow_out
);

  ctrl_req_t         req;
  logic              io_sel;
  logic              is_wr, is_rd;
  logic [BYTE_W-1:0] rd_data_c;
  logic [BYTE_W-1:0] ram [0:(1<<ADDR_WIDTH)-1];
  logic              unused_bits;

  assign req   = '{rw: read_write_flag_from_controller,
                   addr: address_from_controller,
                   data: data_from_controller};
  assign is_wr = rdy_in && (req.rw == WRITE_SIT);
  assign is_rd = rdy_in && (req.rw == READ_SIT);

  // RAM contents survive reset.
  always_ff @(posedge clk_in) begin
    if (is_wr && !io_sel) ram[req.addr[ADDR_WIDTH-1:0]] <= req.data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     data_to_controller <= '0;
    else if (is_rd)  data_to_controller <= rd_data_c;
    else if (is_wr)  data_to_controller <= '0;
  end

`ifdef RAM_RESPONDER_IO_EN
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              base_hit, halt_hit;
  logic              tx_push, tx_pop, rx_pop;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [BYTE_W-1:0] tx_head, rx_head;
  logic [CNT_W-1:0]  tx_count, rx_count;

  assign io_sel   = is_io(req.addr);
  assign base_hit = io_sel && (req.addr[IO_DEC_W-1:0] == IO_BASE);
  assign halt_hit = io_sel && (req.addr[IO_DEC_W-1:0] == IO_HALT);
  assign tx_push  = is_wr && base_hit;
  assign tx_pop   = tx_ready_in && !tx_empty;
  assign rx_pop   = is_rd && base_hit && !rx_empty;

  io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (req.data),
    .pop       (tx_ready_in),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (rx_valid_in),
    .push_data (rx_data_in),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Read-data source select for the registered controller read.
  always_comb begin
    rd_data_c = '0;
    if (!io_sel)       rd_data_c = ram[req.addr[ADDR_WIDTH-1:0]];
    else if (base_hit) rd_data_c = rx_head;
    else if (halt_hit) rd_data_c = {6'b0, rx_full, !rx_empty};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sim_end_out  <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      sim_end_out <= is_wr && halt_hit;
      if (tx_push && tx_full && !tx_pop) overflow_out <= 1'b1;
    end
  end

  assign io_buffer_full_out = tx_full;
  assign tx_valid_out       = !tx_empty;
  assign tx_data_out        = tx_head;
  assign rx_full_out        = rx_full;
  assign unused_bits        = ^{address_from_controller, tx_count, rx_count};
`else
  assign io_sel             = 1'b0;
  assign rd_data_c          = ram[req.addr[ADDR_WIDTH-1:0]];
  assign io_buffer_full_out = 1'b0;
  assign tx_valid_out       = 1'b0;
  assign tx_data_out        = '0;
  assign rx_full_out        = 1'b0;
  assign sim_end_out        = 1'b0;
  assign overflow_out       = 1'b0;
  assign unused_bits        = ^{address_from_controller, tx_ready_in, rx_data_in, rx_valid_in};
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder against a queue/array reference model;
// I/O scenarios run when RAM_RESPONDER_IO_EN is defined.
module tb_ram_responder;

  localparam int unsigned AW    = 17;
  localparam int unsigned DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        read_write_flag_from_controller;
  logic [31:0] address_from_controller;
  logic [7:0]  data_from_controller;
  logic [7:0]  data_to_controller;
  logic        io_buffer_full_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        rx_full_out;
  logic        sim_end_out;
  logic        overflow_out;

  ram_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in                          (clk_in),
    .rst_in                          (rst_in),
    .rdy_in                          (rdy_in),
    .read_write_flag_from_controller (read_write_flag_from_controller),
    .address_from_controller         (address_from_controller),
    .data_from_controller            (data_from_controller),
    .data_to_controller              (data_to_controller),
    .io_buffer_full_out              (io_buffer_full_out),
    .tx_data_out                     (tx_data_out),
    .tx_valid_out                    (tx_valid_out),
    .tx_ready_in                     (tx_ready_in),
    .rx_data_in                      (rx_data_in),
    .rx_valid_in                     (rx_valid_in),
    .rx_full_out                     (rx_full_out),
    .sim_end_out                     (sim_end_out),
    .overflow_out                    (overflow_out)
  );

  always #5 clk_in = ~clk_in;

`ifdef RAM_RESPONDER_IO_EN
  bit io_en = 1'b1;
`else
  bit io_en = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0] ref_ram [int];
  bit   [7:0] tx_q [$];
  bit   [7:0] rx_q [$];
  logic [7:0] exp_dout;
  bit         exp_sim_end;
  bit         exp_ovf;
  int         pool [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    exp_dout    = 8'h00;
    exp_sim_end = 1'b0;
    exp_ovf     = 1'b0;
  endtask

  // One rising edge of the behavioural model, from the currently driven inputs.
  task automatic model_edge();
    logic [31:0] a;
    int          idx;
    bit          io, tx_pop, rx_pop, tx_push, rx_push;
    a       = address_from_controller;
    idx     = int'(a) & ((1 << AW) - 1);
    io      = io_en && (a[17:16] == 2'b11);
    tx_pop  = tx_ready_in && (tx_q.size() != 0);
    rx_pop  = 1'b0;
    tx_push = 1'b0;
    exp_sim_end = 1'b0;
    if (rdy_in) begin
      if (read_write_flag_from_controller) begin
        if (!io) exp_dout = ref_ram[idx];
        else if (a[17:0] == 18'h30000) begin
          if (rx_q.size() != 0) begin exp_dout = rx_q[0]; rx_pop = 1'b1; end
          else exp_dout = 8'h00;
        end else if (a[17:0] == 18'h30004)
          exp_dout = {6'b0, rx_q.size() == DEPTH, rx_q.size() != 0};
        else exp_dout = 8'h00;
      end else begin
        exp_dout = 8'h00;
        if (!io) ref_ram[idx] = data_from_controller;
        else if (a[17:0] == 18'h30000) begin
          if (tx_q.size() < DEPTH || tx_pop) tx_push = 1'b1;
          else exp_ovf = 1'b1;
        end else if (a[17:0] == 18'h30004) exp_sim_end = 1'b1;
      end
    end
    rx_push = io_en && rx_valid_in && (rx_q.size() < DEPTH || rx_pop);
    if (tx_pop)  void'(tx_q.pop_front());
    if (tx_push) tx_q.push_back(data_from_controller);
    if (rx_pop)  void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(rx_data_in);
  endtask

  task automatic check_outputs();
    check_eq("dout", data_to_controller, exp_dout);
    check_eq("tx_valid", tx_valid_out, tx_q.size() != 0);
    check_eq("tx_data", tx_data_out, (tx_q.size() != 0) ? tx_q[0] : 8'h00);
    check_eq("tx_full", io_buffer_full_out, tx_q.size() == DEPTH);
    check_eq("rx_full", rx_full_out, rx_q.size() == DEPTH);
    check_eq("sim_end", sim_end_out, exp_sim_end);
    check_eq("overflow", overflow_out, exp_ovf);
  endtask

  task automatic step(input bit rdy, input bit rw, input logic [31:0] addr,
                      input logic [7:0] data, input bit txr, input bit rxv,
                      input logic [7:0] rxd);
    rdy_in                          = rdy;
    read_write_flag_from_controller = rw;
    address_from_controller         = addr;
    data_from_controller            = data;
    tx_ready_in                     = txr;
    rx_valid_in                     = rxv;
    rx_data_in                      = rxd;
    @(posedge clk_in);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit txr);
    step(1'b0, 1'b0, 32'h0, 8'h00, txr, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  held;
    rst_in = 1'b0;
    rdy_in = 1'b0;
    read_write_flag_from_controller = 1'b0;
    address_from_controller = '0;
    data_from_controller = '0;
    tx_ready_in = 1'b0;
    rx_valid_in = 1'b0;
    rx_data_in = '0;
    model_reset();
    #12;
    check_eq("rst_dout", data_to_controller, 8'h00);
    check_eq("rst_tx_valid", tx_valid_out, 1'b0);
    check_eq("rst_tx_data", tx_data_out, 8'h00);
    check_eq("rst_sim_end", sim_end_out, 1'b0);
    check_eq("rst_overflow", overflow_out, 1'b0);
    rst_in = 1'b1;

    // RAM write then read-back one cycle later
    step(1'b1, 1'b0, 32'h0000_0100, 8'hA5, 1'b0, 1'b0, 8'h00);
    check_eq("wr_dout_zero", data_to_controller, 8'h00);
    step(1'b1, 1'b1, 32'h0000_0100, 8'h00, 1'b0, 1'b0, 8'h00);
    check_eq("rd_a5", data_to_controller, 8'hA5);

    // rdy_in low suppresses the write and holds the read data
    step(1'b1, 1'b0, 32'h0000_0200, 8'h11, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 32'h0000_0100, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 32'h0000_0200, 8'h22, 1'b0, 1'b0, 8'h00);
    check_eq("rdy_low_hold", data_to_controller, 8'hA5);
    step(1'b1, 1'b1, 32'h0000_0200, 8'h00, 1'b0, 1'b0, 8'h00);
    check_eq("rdy_low_no_write", data_to_controller, 8'h11);

`ifdef RAM_RESPONDER_IO_EN
    // TX fill to full, one overflow, then host drains in order
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b0, 32'h0003_0000, 8'(k), 1'b0, 1'b0, 8'h00);
      if (k == 8) check_eq("tx_full_after8", io_buffer_full_out, 1'b1);
    end
    check_eq("overflow_set", overflow_out, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      check_eq("drain_order", tx_data_out, 8'(k));
      idle(1'b1);
    end
    check_eq("drained", tx_valid_out, 1'b0);

    // RX push, status read, pop, empty read
    step(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 8'h41);
    step(1'b1, 1'b1, 32'hFFF3_0004, 8'h00, 1'b0, 1'b0, 8'h00);
    check_eq("rx_status", data_to_controller, 8'h01);
    step(1'b1, 1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
    check_eq("rx_read", data_to_controller, 8'h41);
    step(1'b1, 1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
    check_eq("rx_empty_read", data_to_controller, 8'h00);

    // Halt write pulses sim_end for one cycle
    step(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
    check_eq("sim_end_pulse", sim_end_out, 1'b1);
    idle(1'b0);
    check_eq("sim_end_clear", sim_end_out, 1'b0);
`else
    // Without I/O the window aliases into RAM and I/O outputs stay low
    step(1'b1, 1'b0, 32'h0003_0004, 8'h5C, 1'b0, 1'b1, 8'h41);
    check_eq("no_io_sim_end", sim_end_out, 1'b0);
    step(1'b1, 1'b1, 32'h0001_0004, 8'h00, 1'b1, 1'b0, 8'h00);
    check_eq("no_io_alias", data_to_controller, 8'h5C);
`endif

    // Asynchronous reset in the middle of a drain
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 32'h0003_0000, 8'hC0 + 8'(k), 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 32'h0000_0100, 8'h00, 1'b1, 1'b0, 8'h00);
    #3;
    rst_in = 1'b0;
    #1;
    check_eq("async_tx_valid", tx_valid_out, 1'b0);
    check_eq("async_tx_data", tx_data_out, 8'h00);
    check_eq("async_dout", data_to_controller, 8'h00);
    check_eq("async_overflow", overflow_out, 1'b0);
    check_eq("async_tx_full", io_buffer_full_out, 1'b0);
    model_reset();
    rst_in = 1'b1;
    step(1'b1, 1'b1, 32'h0000_0100, 8'h00, 1'b0, 1'b0, 8'h00);
    check_eq("ram_kept", data_to_controller, 8'hA5);

    // Initialise the random address pool and the I/O-window addresses
    for (int i = 0; i < 16; i++) begin
      pool[i] = int'($urandom_range(0, 32'h0000_FFFF));
      step(1'b1, 1'b0, 32'(pool[i]), 8'($urandom), 1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 32'h0003_0000 + 32'(4 * i), 8'($urandom), 1'b1, 1'b0, 8'h00);

    // Random traffic on both sides
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) != 0)
        a = {$urandom_range(0, 32'h7FFF) & 32'h7FFF, 17'h0} | 32'(pool[$urandom_range(0, 15)]);
      else
        a = {14'($urandom), 18'h30000 + 18'(4 * $urandom_range(0, 2))};
      held = 8'($urandom);
      step($urandom_range(0, 3) != 0, 1'($urandom), a, held,
           1'($urandom), $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
